mul_share_arbiter: RTL

Round-robin arbiter that time-shares one 192-bit modular multiplier (`Multiplication_192x192`) among `NREQ` requesters, e.g. two `ECpoint_scalar` datapaths or a scalar engine plus a signature engine. It latches the winning requester's operands and issues a one-cycle start pulse to the multiplier. It then waits for the multiplier's valid, returns the product with a per-requester done pulse, and rotates priority. A watchdog aborts an operation whose valid never arrives.

---
 rtl/mul_share_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Round-robin owner of one shared BW x BW modular multiplier. The winner's
// operands are latched on the grant edge, a one-cycle start pulse restarts the
// multiplier, and the product comes back with a per-requester done pulse. A
// watchdog turns a missing mul_valid into an err pulse so a requester never
// waits forever.
//
// Handshake: req[i] is a level held until done[i] or err[i] pulses. gnt is
// one-hot and registered from the grant edge through the RETIRE cycle.
// mul_valid is honoured only in WAIT. done/err are single-cycle pulses in
// RETIRE. result is valid while done is high and holds its value otherwise.
module mul_share_arbiter #(
    parameter int NREQ    = 2,
    parameter int BW      = 192,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BW-1:0]   op_a,
    input  logic [NREQ*BW-1:0]   op_b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [BW-1:0]        result,
    output logic                 busy,
    output logic                 mul_start,
    output logic [BW-1:0]        mul_a,
    output logic [BW-1:0]        mul_b,
    input  logic [BW-1:0]        mul_prod,
    input  logic                 mul_valid,
    output logic [1:0]           state_dbg
);

    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [BW-1:0]     result_q, result_d;
    logic              mul_start_q, mul_start_d;
    logic [BW-1:0]     mul_a_q, mul_a_d;
    logic [BW-1:0]     mul_b_q, mul_b_d;
    logic [WDW-1:0]    wd_q, wd_d;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [IW:0]       cand;
    logic [BW-1:0]     sel_a, sel_b;
    logic [IW-1:0]     ptr_after_owner;

    // Search upward from the pointer; iterating downward lets the nearest hit win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if ((req & (NREQ'(1) << cand)) != '0) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Pick the winner's operand slices for latching on the grant edge.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IW'(k)) begin
                sel_a = op_a[k*BW +: BW];
                sel_b = op_b[k*BW +: BW];
            end
        end
    end

    // Priority moves just past the owner that retired.
    always_comb begin
        if (owner_q == IW'(NREQ - 1)) begin
            ptr_after_owner = '0;
        end else begin
            ptr_after_owner = owner_q + IW'(1);
        end
    end

    // Next-state and registered-output logic for IDLE/ISSUE/WAIT/RETIRE.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = '0;
        result_d    = result_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        wd_d        = wd_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d       = NREQ'(1) << win_idx;
                    owner_d     = win_idx;
                    mul_a_d     = sel_a;
                    mul_b_d     = sel_b;
                    // Registered, so the pulse is high exactly during ISSUE.
                    mul_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WDW'(1);
                // A product landing on the timeout edge still counts as success.
                if (mul_valid) begin
                    result_d = mul_prod;
                    done_d   = gnt_q;
                    state_d  = S_RETIRE;
                end else if (wd_q == WDW'(TIMEOUT)) begin
                    err_d   = gnt_q;
                    state_d = S_RETIRE;
                end
            end
            S_RETIRE: begin
                gnt_d   = '0;
                ptr_d   = ptr_after_owner;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; async reset returns everything to idle zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            result_q    <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            wd_q        <= wd_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE);
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign state_dbg = state_q;

endmodule
